// File: rtl/softmax_ifm_sender.sv
// -----------------------------------------------------------------------------
// softmax_ifm_sender
//   On-chip frame source for the softmax datapath. A frame of IFM_SIZE words is
//   loaded into a local buffer while idle, then streamed word-by-word on
//   valid_ifm/ifm when start is seen. The consumer can stall the stream with
//   hold. After the last word, frame_done pulses for one cycle and a forced gap
//   of GAP_CYCLES idle cycles follows before the next frame can start.
//
// Ports
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   load_en        write load_data into the buffer at load_addr (IDLE only)
//   load_addr      buffer write address; addresses >= IFM_SIZE are ignored
//   load_data      buffer write data
//   start          begin transmitting the buffered frame (IDLE only)
//   hold           stall: no new word is emitted while high
//   valid_ifm      ifm carries a valid word this cycle
//   ifm            IFM word
//   busy           high while sending and during the inter-frame gap
//   frame_done     one-cycle pulse after the last word
//   counter_ifm    number of words emitted in the current/last frame
// -----------------------------------------------------------------------------
module softmax_ifm_sender #(
  parameter int DATA_WIDTH_IN = 16,
  parameter int IFM_SIZE      = 1000,
  parameter int ADD_WIDTH     = 10,
  parameter int GAP_CYCLES    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_en,
  input  logic [ADD_WIDTH-1:0]     load_addr,
  input  logic [DATA_WIDTH_IN-1:0] load_data,
  input  logic                     start,
  input  logic                     hold,
  output logic                     valid_ifm,
  output logic [DATA_WIDTH_IN-1:0] ifm,
  output logic                     busy,
  output logic                     frame_done,
  output logic [15:0]              counter_ifm
);

  // idx is one bit wider than the buffer address so that the "all words sent"
  // value IFM_SIZE is representable without wrapping to zero.
  localparam int IDX_W = ADD_WIDTH + 1;
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(IFM_SIZE);

  localparam int GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LAST_I);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                   state;
  logic [IDX_W-1:0]         idx;
  logic [GAP_W-1:0]         gap_cnt;
  logic [DATA_WIDTH_IN-1:0] mem [0:IFM_SIZE-1];
  logic                     wr_en;

  // The buffer is only writable while idle; a start on the same edge wins and
  // the load is dropped. Out-of-range addresses are discarded.
  assign wr_en = (state == IDLE) && load_en && !start &&
                 ({1'b0, load_addr} < IDX_END);

  // Buffer storage: deliberately not reset so a frame survives rst.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      gap_cnt     <= '0;
      valid_ifm   <= 1'b0;
      ifm         <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      counter_ifm <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          valid_ifm <= 1'b0;
          // Word 0 goes out on the start edge regardless of hold.
          if (start) begin
            valid_ifm   <= 1'b1;
            ifm         <= mem[0];
            idx         <= IDX_W'(1);
            counter_ifm <= 16'd1;
            busy        <= 1'b1;
            state       <= SEND;
          end
        end

        SEND: begin
          if (hold) begin
            valid_ifm <= 1'b0;
          end else if (idx < IDX_END) begin
            valid_ifm   <= 1'b1;
            ifm         <= mem[idx[ADD_WIDTH-1:0]];
            idx         <= idx + IDX_W'(1);
            counter_ifm <= counter_ifm + 16'd1;
          end else begin
            valid_ifm  <= 1'b0;
            frame_done <= 1'b1;
            gap_cnt    <= '0;
            if (GAP_CYCLES == 0) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= GAP;
            end
          end
        end

        GAP: begin
          // The frame_done cycle is the first gap cycle; busy drops on the
          // GAP_CYCLES-th edge after frame_done was raised.
          valid_ifm <= 1'b0;
          if (gap_cnt == GAP_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: begin
          valid_ifm <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_ifm_sender.sv
// -----------------------------------------------------------------------------
// tb_softmax_ifm_sender
//   Randomized self-checking bench. Instance u_dut uses the default build
//   (1000 words, 4 gap cycles); u_dut_b is a small build with no gap, used for
//   the back-to-back restart behaviour. A plain array holds the expected buffer
//   contents; expected stream behaviour is derived from the stream rules.
// -----------------------------------------------------------------------------
module tb_softmax_ifm_sender;

  localparam int N   = 1000;
  localparam int GAP = 4;
  localparam int NB  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        load_en;
  logic [9:0]  load_addr;
  logic [15:0] load_data;
  logic        start;
  logic        hold;
  logic        valid_ifm;
  logic [15:0] ifm;
  logic        busy;
  logic        frame_done;
  logic [15:0] counter_ifm;

  logic        b_load_en;
  logic [2:0]  b_load_addr;
  logic [15:0] b_load_data;
  logic        b_start;
  logic        b_hold;
  logic        b_valid;
  logic [15:0] b_ifm;
  logic        b_busy;
  logic        b_frame_done;
  logic [15:0] b_counter;

  int checks   = 0;
  int failures = 0;
  int model   [N];
  int model_b [NB];

  softmax_ifm_sender #(
    .DATA_WIDTH_IN(16), .IFM_SIZE(N), .ADD_WIDTH(10), .GAP_CYCLES(GAP)
  ) u_dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .hold(hold),
    .valid_ifm(valid_ifm), .ifm(ifm), .busy(busy),
    .frame_done(frame_done), .counter_ifm(counter_ifm)
  );

  softmax_ifm_sender #(
    .DATA_WIDTH_IN(16), .IFM_SIZE(NB), .ADD_WIDTH(3), .GAP_CYCLES(0)
  ) u_dut_b (
    .clk(clk), .rst(rst), .load_en(b_load_en), .load_addr(b_load_addr),
    .load_data(b_load_data), .start(b_start), .hold(b_hold),
    .valid_ifm(b_valid), .ifm(b_ifm), .busy(b_busy),
    .frame_done(b_frame_done), .counter_ifm(b_counter)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input int addr, input int data);
    load_en   = 1'b1;
    load_addr = 10'(addr);
    load_data = 16'(data);
    step();
    load_en   = 1'b0;
  endtask

  // Sends one frame and checks it against model[]. hold_pct: random stall
  // probability; hold_word: force 3 stall cycles once this many words are out
  // (-1 disables); poke: fire start and a write to address 5 throughout the
  // frame and gap; load_at_start: present a write together with start.
  task automatic run_frame(input int hold_pct, input int hold_word,
                           input bit poke, input bit load_at_start);
    int got;
    int cyc;
    int hcnt;
    int gbusy;
    bit h;
    bit full;
    bit done;
    start = 1'b1;
    hold  = 1'($urandom_range(0, 1));
    if (load_at_start) begin
      load_en   = 1'b1;
      load_addr = 10'd3;
      load_data = 16'(model[3]) ^ 16'h5a5a;
    end
    step();
    start   = 1'b0;
    load_en = 1'b0;
    check("first_valid", valid_ifm, 1);
    check("first_word", ifm, model[0]);
    check("first_cnt", counter_ifm, 1);
    check("first_busy", busy, 1);
    got  = 1;
    cyc  = 0;
    hcnt = 0;
    done = 1'b0;
    while (!done && cyc < 3 * N) begin
      h = ($urandom_range(0, 99) < hold_pct);
      if (got == hold_word && hcnt < 3) begin
        h = 1'b1;
        hcnt++;
      end
      hold = h;
      if (poke) begin
        start     = 1'($urandom_range(0, 1));
        load_en   = 1'b1;
        load_addr = 10'd5;
        load_data = ~16'(model[5]);
      end
      full = (got == N);
      step();
      cyc++;
      check("valid", valid_ifm, 32'(!h && !full));
      check("frame_done", frame_done, 32'(!h && full));
      if (valid_ifm) begin
        if (got < N) check("word", ifm, model[got]);
        got++;
      end
      check("counter", counter_ifm, got);
      if (frame_done) done = 1'b1;
    end
    hold = 1'b0;
    if (!done) check("frame_timeout", 0, 1);
    check("words_total", got, N);
    gbusy = 0;
    for (int i = 0; i < 20 && busy; i++) begin
      gbusy++;
      check("gap_valid", valid_ifm, 0);
      check("gap_cnt", counter_ifm, N);
      if (poke) begin
        start   = 1'b1;
        load_en = 1'b1;
      end
      step();
      check("gap_fd", frame_done, 0);
    end
    start   = 1'b0;
    load_en = 1'b0;
    check("gap_len", gbusy, GAP);
    step();
    check("idle_busy", busy, 0);
    check("idle_valid", valid_ifm, 0);
    check("idle_cnt", counter_ifm, N);
  endtask

  initial begin
    rst = 1'b1;
    load_en = 1'b0; load_addr = '0; load_data = '0; start = 1'b0; hold = 1'b0;
    b_load_en = 1'b0; b_load_addr = '0; b_load_data = '0; b_start = 1'b0; b_hold = 1'b0;
    #22;
    check("rst_valid", valid_ifm, 0);
    check("rst_ifm", ifm, 0);
    check("rst_busy", busy, 0);
    check("rst_fd", frame_done, 0);
    check("rst_cnt", counter_ifm, 0);
    check("rst_b_busy", b_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Ramp frame, no stalls, then a frame with a 3-cycle stall after word 10
    for (int i = 0; i < N; i++) begin
      model[i] = i + 1;
      load_word(i, i + 1);
    end
    run_frame(0, -1, 1'b0, 1'b0);
    run_frame(0, 10, 1'b0, 1'b0);

    // Random data; start/write attempts while busy must be ignored
    for (int i = 0; i < N; i++) begin
      model[i] = int'($urandom_range(0, 65535));
      load_word(i, model[i]);
    end
    run_frame(25, -1, 1'b1, 1'b0);

    // Out-of-range write and write on the start edge must not land
    load_word(N, 16'hdead);
    run_frame(10, -1, 1'b0, 1'b1);

    // Asynchronous abort mid-frame, then a clean resend
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 2000 && counter_ifm != 16'd500; c++) step();
    check("pre_rst_cnt", counter_ifm, 500);
    #2;
    rst = 1'b1;
    #1;
    check("abort_valid", valid_ifm, 0);
    check("abort_busy", busy, 0);
    check("abort_cnt", counter_ifm, 0);
    check("abort_ifm", ifm, 0);
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      check("post_rst_fd", frame_done, 0);
      check("post_rst_valid", valid_ifm, 0);
      check("post_rst_busy", busy, 0);
    end
    run_frame(0, -1, 1'b0, 1'b0);

    // Zero-gap build: busy falls with frame_done, immediate restart accepted
    for (int i = 0; i < NB; i++) begin
      model_b[i] = int'($urandom_range(0, 65535));
      b_load_en   = 1'b1;
      b_load_addr = 3'(i);
      b_load_data = 16'(model_b[i]);
      step();
    end
    b_load_en = 1'b0;
    for (int f = 0; f < 2; f++) begin
      b_start = 1'b1;
      step();
      b_start = 1'b0;
      check("b_first_valid", b_valid, 1);
      check("b_first_word", b_ifm, model_b[0]);
      check("b_first_busy", b_busy, 1);
      check("b_first_cnt", b_counter, 1);
      check("b_first_fd", b_frame_done, 0);
      for (int i = 1; i < NB; i++) begin
        step();
        check("b_valid", b_valid, 1);
        check("b_word", b_ifm, model_b[i]);
      end
      step();
      check("b_fd", b_frame_done, 1);
      check("b_busy_fall", b_busy, 0);
      check("b_end_valid", b_valid, 0);
      check("b_cnt", b_counter, NB);
    end
    step();
    check("b_idle_fd", b_frame_done, 0);
    check("b_idle_busy", b_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
